// File: rtl/cella_array_pkg.sv
// Shared encodings, default field widths and command layout for the CELLA array sequencer.
package cella_array_pkg;

    localparam logic [1:0] OP_READ   = 2'b00;
    localparam logic [1:0] OP_WRITE  = 2'b01;
    localparam logic [1:0] OP_SEARCH = 2'b10;
    localparam logic [1:0] OP_IDLE   = 2'b11;

    localparam int unsigned DEF_BANK_W = 4;
    localparam int unsigned DEF_ROW_W  = 2;
    localparam int unsigned DEF_COL_W  = 3;
    localparam int unsigned DEF_DATA_W = 16;
    localparam int unsigned DEF_CNT_W  = 4;
    localparam int unsigned DEF_ADDR_W = DEF_BANK_W + DEF_ROW_W + DEF_COL_W;

    typedef enum logic {StIdle, StIssue} seq_state_e;

    // Command layout at the default widths; the sequencer packs the same field order.
    typedef struct packed {
        logic [1:0]            op;
        logic [DEF_ADDR_W-1:0] addr;
        logic [DEF_DATA_W-1:0] data_bank;
        logic [DEF_DATA_W-1:0] data_in;
        logic [DEF_CNT_W-1:0]  count;
        logic                  sweep;
    } cmd_t;

    function automatic int unsigned cmd_width(int unsigned addr_w, int unsigned data_w,
                                              int unsigned cnt_w);
        return 2 + addr_w + 2 * data_w + cnt_w + 1;
    endfunction

endpackage

// File: rtl/cmd_fifo.sv
// Synchronous command FIFO with full/empty flags; head word is visible combinationally.
module cmd_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);
    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W:0]   wr_q, rd_q;
    logic             do_push, do_pop;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign empty   = (wr_q == rd_q);
    assign full    = (wr_q[PTR_W] != rd_q[PTR_W]) && (wr_q[PTR_W-1:0] == rd_q[PTR_W-1:0]);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_q[PTR_W-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + 1'b1;
            if (do_pop)  rd_q <= rd_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_q[PTR_W-1:0]] <= wdata;
    end

endmodule

// File: rtl/array_cmd_sequencer.sv
// Queues host commands and issues them to the CELLA array one op per clock,
// with repeat counts and optional row/column auto-sweep.
module array_cmd_sequencer
    import cella_array_pkg::*;
#(
    parameter int unsigned BANK_W     = DEF_BANK_W,
    parameter int unsigned ROW_W      = DEF_ROW_W,
    parameter int unsigned COL_W      = DEF_COL_W,
    parameter int unsigned DATA_W     = DEF_DATA_W,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned CNT_W      = DEF_CNT_W,
    localparam int unsigned ADDR_W    = BANK_W + ROW_W + COL_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_data_bank,
    input  logic [DATA_W-1:0] cmd_data_in,
    input  logic [CNT_W-1:0]  cmd_count,
    input  logic              cmd_sweep,
    output logic [1:0]        op_code,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] data_bank,
    output logic [DATA_W-1:0] data_in,
    output logic              cmd_done,
    output logic              busy
);
    localparam int unsigned CMD_W = cmd_width(ADDR_W, DATA_W, CNT_W);

    logic [CMD_W-1:0]  fifo_wdata, fifo_rdata;
    logic              fifo_full, fifo_empty, fifo_pop;

    logic [1:0]        h_op;
    logic [ADDR_W-1:0] h_addr;
    logic [DATA_W-1:0] h_db, h_di;
    logic [CNT_W-1:0]  h_cnt;
    logic              h_sweep;

    seq_state_e        state_q, state_d;
    logic [1:0]        op_q, op_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] db_q, db_d, di_q, di_d;
    logic [CNT_W-1:0]  rem_q, rem_d;
    logic              sweep_q, sweep_d;
    logic              done_q, done_d;
    logic              load;

    assign fifo_wdata = {cmd_op, cmd_addr, cmd_data_bank, cmd_data_in, cmd_count, cmd_sweep};
    assign {h_op, h_addr, h_db, h_di, h_cnt, h_sweep} = fifo_rdata;

    cmd_fifo #(
        .WIDTH (CMD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_cmd_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (cmd_valid),
        .wdata (fifo_wdata),
        .pop   (fifo_pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Next command loads from idle or straight after a final issue, so there is no bubble.
    assign load = !fifo_empty && ((state_q == StIdle) || (rem_q == '0));

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        addr_d   = addr_q;
        db_d     = db_q;
        di_d     = di_q;
        rem_d    = rem_q;
        sweep_d  = sweep_q;
        done_d   = 1'b0;
        fifo_pop = 1'b0;
        if (load) begin
            fifo_pop = 1'b1;
            state_d  = StIssue;
            op_d     = h_op;
            addr_d   = h_addr;
            db_d     = h_db;
            di_d     = h_di;
            rem_d    = h_cnt;
            sweep_d  = h_sweep;
            done_d   = (h_cnt == '0);
        end else if (state_q == StIssue) begin
            if (rem_q != '0) begin
                rem_d  = rem_q - 1'b1;
                done_d = (rem_q == CNT_W'(1));
                if (sweep_q) begin
                    // Fields wrap within their own width; no carry into neighbours.
                    case (op_q)
                        OP_READ, OP_WRITE: addr_d[COL_W +: ROW_W] = addr_q[COL_W +: ROW_W] + 1'b1;
                        OP_SEARCH:         addr_d[0 +: COL_W]     = addr_q[0 +: COL_W] + 1'b1;
                        default:           addr_d = addr_q;
                    endcase
                end
            end else begin
                op_d    = OP_IDLE;
                state_d = StIdle;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            op_q    <= OP_IDLE;
            addr_q  <= '0;
            db_q    <= '0;
            di_q    <= '0;
            rem_q   <= '0;
            sweep_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            db_q    <= db_d;
            di_q    <= di_d;
            rem_q   <= rem_d;
            sweep_q <= sweep_d;
            done_q  <= done_d;
        end
    end

    assign op_code   = op_q;
    assign addr      = addr_q;
    assign data_bank = db_q;
    assign data_in   = di_q;
    assign cmd_done  = done_q;
    assign cmd_ready = !fifo_full;
    assign busy      = (state_q == StIssue) || !fifo_empty;

endmodule

// File: tb/tb_array_cmd_sequencer.sv
// Scoreboard bench: accepted commands expand into expected issue records that a monitor checks.
module tb_array_cmd_sequencer;
    import cella_array_pkg::*;

    logic        clk, rst_n;
    logic        cmd_valid, cmd_ready;
    logic [1:0]  cmd_op;
    logic [8:0]  cmd_addr;
    logic [15:0] cmd_data_bank, cmd_data_in;
    logic [3:0]  cmd_count;
    logic        cmd_sweep;
    logic [1:0]  op_code;
    logic [8:0]  addr;
    logic [15:0] data_bank, data_in;
    logic        cmd_done, busy;

    array_cmd_sequencer #(
        .BANK_W     (4),
        .ROW_W      (2),
        .COL_W      (3),
        .DATA_W     (16),
        .FIFO_DEPTH (4),
        .CNT_W      (4)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_op        (cmd_op),
        .cmd_addr      (cmd_addr),
        .cmd_data_bank (cmd_data_bank),
        .cmd_data_in   (cmd_data_in),
        .cmd_count     (cmd_count),
        .cmd_sweep     (cmd_sweep),
        .op_code       (op_code),
        .addr          (addr),
        .data_bank     (data_bank),
        .data_in       (data_in),
        .cmd_done      (cmd_done),
        .busy          (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]  op;
        logic [8:0]  addr;
        logic [15:0] db;
        logic [15:0] di;
        logic        done;
    } exp_t;

    exp_t       exp_q[$];
    exp_t       mon_e;
    logic [2:0] op_log[$];
    bit         log_en;
    int         total, bad, done_seen;

    // Visible issues: every non-idle op plus the final cycle of a NOP (marked by cmd_done).
    always @(negedge clk) begin
        if (rst_n) begin
            if (cmd_done) done_seen++;
            if (log_en) op_log.push_back({op_code, cmd_done});
            if (op_code != 2'b11 || cmd_done) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL sb_extra: got op=%h addr=%h done=%b, want no issue",
                             op_code, addr, cmd_done);
                end else begin
                    mon_e = exp_q.pop_front();
                    if ({op_code, addr, data_bank, data_in, cmd_done} !== mon_e) begin
                        bad++;
                        $display("FAIL sb_issue: got op=%h addr=%h db=%h di=%h done=%b, want op=%h addr=%h db=%h di=%h done=%b",
                                 op_code, addr, data_bank, data_in, cmd_done,
                                 mon_e.op, mon_e.addr, mon_e.db, mon_e.di, mon_e.done);
                    end
                end
            end
        end
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, got, want);
        end
    endtask

    // Reference model: issue i of a command sees its start field advanced by i, modulo field size.
    task automatic expect_cmd(input logic [1:0] op, input logic [8:0] a, input logic [15:0] db,
                              input logic [15:0] di, input logic [3:0] cnt, input logic sw);
        logic [1:0] r;
        logic [2:0] c;
        if (op == 2'b11) begin
            exp_q.push_back({2'b11, a, db, di, 1'b1});
            return;
        end
        for (int i = 0; i <= int'(cnt); i++) begin
            r = a[4:3];
            c = a[2:0];
            if (sw && op != 2'b10) r = 2'((int'(a[4:3]) + i) % 4);
            if (sw && op == 2'b10) c = 3'((int'(a[2:0]) + i) % 8);
            exp_q.push_back({op, a[8:5], r, c, db, di, (i == int'(cnt))});
        end
    endtask

    // Called at a negedge; returns at the following negedge with cmd_valid dropped.
    task automatic send(input logic [1:0] op, input logic [8:0] a, input logic [15:0] db,
                        input logic [15:0] di, input logic [3:0] cnt, input logic sw,
                        output bit acc);
        cmd_op = op; cmd_addr = a; cmd_data_bank = db; cmd_data_in = di;
        cmd_count = cnt; cmd_sweep = sw; cmd_valid = 1'b1;
        #1;
        acc = cmd_ready;
        if (acc) expect_cmd(op, a, db, di, cnt, sw);
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while ((busy || op_code != 2'b11) && n < 300) begin
            @(negedge clk);
            n++;
        end
        check(name, 64'(n < 300), 64'd1);
    endtask

    bit         acc;
    cmd_t       c;
    int         base, k, gaps, span;
    logic [9:0] seq;

    initial begin
        total = 0; bad = 0; done_seen = 0; log_en = 1'b0;
        cmd_valid = 1'b0; cmd_op = 2'b11; cmd_addr = '0; cmd_data_bank = '0;
        cmd_data_in = '0; cmd_count = '0; cmd_sweep = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_op", 64'(op_code), 64'h3);
        check("rst_addr_data", 64'({addr, data_bank, data_in}), 64'h0);
        check("rst_busy_done", 64'({busy, cmd_done}), 64'h0);
        check("rst_ready", 64'(cmd_ready), 64'h1);
        rst_n = 1'b1;
        @(negedge clk);

        // Single write: first issue one cycle after the accepting edge.
        send(2'b01, 9'h000, 16'h00FF, 16'h1234, 4'd0, 1'b0, acc);
        check("wr_accept", 64'(acc), 64'h1);
        check("wr_pending", 64'({busy, op_code}), 64'h7);
        @(negedge clk);
        check("wr_issue", 64'({op_code, cmd_done}), 64'h3);
        @(negedge clk);
        check("wr_after", 64'({op_code, cmd_done}), 64'h6);
        wait_idle("wr_idle");

        send(2'b00, 9'b0110_10_101, 16'hA5A5, 16'h5A5A, 4'd3, 1'b1, acc);
        wait_idle("row_sweep_idle");
        send(2'b10, 9'b0000_00_110, 16'h000F, 16'h0000, 4'd2, 1'b1, acc);
        wait_idle("col_sweep_idle");

        // Fill the queue behind a long NOP; the fifth push must be refused.
        op_log.delete(); log_en = 1'b1; base = done_seen; span = 0;
        send(2'b11, 9'($urandom), 16'($urandom), 16'($urandom), 4'd15, 1'b1, acc);
        for (int i = 0; i < 4; i++) begin
            c.op = 2'($urandom_range(0, 2)); c.count = 4'($urandom_range(0, 3));
            send(c.op, 9'($urandom), 16'($urandom), 16'($urandom), c.count, 1'($urandom), acc);
            check("full_push_ok", 64'(acc), 64'h1);
            span += int'(c.count) + 1;
        end
        send(2'b00, 9'h1FF, 16'hDEAD, 16'hBEEF, 4'd0, 1'b0, acc);
        check("full_ready_low", 64'(acc), 64'h0);
        wait_idle("full_idle");
        log_en = 1'b0;
        check("full_done_count", 64'(done_seen - base), 64'd5);
        k = -1; gaps = 0;
        foreach (op_log[i]) if (k < 0 && op_log[i][0]) k = i;
        if (k < 0 || k + span >= op_log.size()) gaps = 99;
        else for (int i = k + 1; i <= k + span; i++) if (op_log[i][2:1] == 2'b11) gaps++;
        check("b2b_no_gap", 64'(gaps), 64'd0);

        // NOP gap between a write and a read.
        op_log.delete(); log_en = 1'b1;
        send(2'b01, 9'h021, 16'h1111, 16'h2222, 4'd0, 1'b0, acc);
        send(2'b11, 9'h0A3, 16'h3333, 16'h4444, 4'd2, 1'b0, acc);
        send(2'b00, 9'h145, 16'h5555, 16'h6666, 4'd0, 1'b0, acc);
        wait_idle("nop_idle");
        log_en = 1'b0;
        k = -1; seq = '1;
        foreach (op_log[i]) if (k < 0 && op_log[i][2:1] == 2'b01) k = i;
        if (k >= 0 && k + 4 < op_log.size())
            seq = {op_log[k][2:1], op_log[k+1][2:1], op_log[k+2][2:1],
                   op_log[k+3][2:1], op_log[k+4][2:1]};
        check("nop_gap_seq", 64'(seq), 64'b01_11_11_11_00);

        for (int n = 0; n < 50; n++) begin
            c.op = 2'($urandom); c.addr = 9'($urandom); c.data_bank = 16'($urandom);
            c.data_in = 16'($urandom); c.count = 4'($urandom_range(0, 5));
            c.sweep = 1'($urandom);
            send(c.op, c.addr, c.data_bank, c.data_in, c.count, c.sweep, acc);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        wait_idle("rand_idle");
        check("rand_drained", 64'(exp_q.size()), 64'd0);

        // Reset in the middle of a sweep clears everything immediately.
        send(2'b00, 9'b1010_01_011, 16'hCAFE, 16'hF00D, 4'd15, 1'b1, acc);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        check("midrst_op", 64'(op_code), 64'h3);
        check("midrst_fields", 64'({addr, data_bank, data_in, cmd_done, busy}), 64'h0);
        check("midrst_ready", 64'(cmd_ready), 64'h1);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("post_rst_idle", 64'({busy, op_code}), 64'h3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/array_cmd_sequencer.md
# array_cmd_sequencer

Parametrised command sequencer driving the CELLA array's op_code/addr/data_bank/data_in port. It accepts queued commands over a valid/ready interface and issues them to the array one operation per clock. Each command carries a repeat count and can auto-sweep the row field (read/write) or the column field (search). It replaces hand-timed stimulus and sits between the host/testbench command source and the array.

## Interface
Parameters:
- BANK_W, 4, bank field width (addr MSBs)
- ROW_W, 2, row field width (addr middle)
- COL_W, 3, column field width (addr LSBs)
- DATA_W, 16, data_bank / data_in width
- FIFO_DEPTH, 4, command queue depth (power of 2, ≥2)
- CNT_W, 4, repeat-count width

Ports (ADDR_W = BANK_W+ROW_W+COL_W; addr = {bank, row, col}):
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  queue can accept (= !full)
- cmd_op  in  2  00 read, 01 write, 10 search, 11 NOP/gap
- cmd_addr  in  ADDR_W  start address
- cmd_data_bank  in  DATA_W  data_bank payload
- cmd_data_in  in  DATA_W  data_in payload
- cmd_count  in  CNT_W  issues = cmd_count+1
- cmd_sweep  in  1  auto-increment field per issue
- op_code  out  2  to array
- addr  out  ADDR_W  to array
- data_bank  out  DATA_W  to array
- data_in  out  DATA_W  to array
- cmd_done  out  1  one-cycle pulse on a command's final issue cycle
- busy  out  1  state ISSUE or queue non-empty

## Operation
- Queue: push on cmd_valid & cmd_ready. No push when full, even with a simultaneous pop. Push and pop in the same cycle are allowed when not full.
- FSM IDLE: outputs op_code=11; addr, data_bank and data_in hold their last values.
  - Queue non-empty at an edge: pop head, load outputs from its fields, remaining=cmd_count, go to ISSUE.
- FSM ISSUE, remaining≠0: decrement remaining.
  - If sweep: op 00/01 increment the row field; op 10 increments the col field; bank and the other field are unchanged. The field wraps modulo 2^width without carrying into its neighbour. NOP ignores sweep.
  - data_bank and data_in are held.
- FSM ISSUE, remaining=0: this is the final cycle and cmd_done=1.
  - At the next edge, if the queue is non-empty, load the next command back-to-back with no bubble.
  - Otherwise op_code=11 and go to IDLE.
- NOP command (op 11): holds op_code=11 for cmd_count+1 cycles, with addr and data taken from the command; cmd_done fires as normal.
- Reset (any time, including mid-command): immediately clears the queue and FSM (→IDLE).
  - op_code=11; addr, data_bank, data_in=0; cmd_done=0; busy=0; cmd_ready=1 after reset.

## Timing
- All array outputs and cmd_done are registered.
- Command accepted at edge t into an empty, idle sequencer: its first issue is visible after edge t+1.
- Each issue lasts exactly one cycle. A command occupies cmd_count+1 consecutive cycles.
- Back-to-back commands: issue cycles are contiguous.
- cmd_done asserts coincident with the last issue cycle only, never in IDLE.
- busy is combinational from state and queue occupancy.

## Structure
- Package cella_array_pkg holds:
  - op encodings OP_READ=2'b00, OP_WRITE=2'b01, OP_SEARCH=2'b10, OP_IDLE=2'b11
  - default field widths
  - a packed command struct {op, addr, data_bank, data_in, count, sweep}
- Sub-module cmd_fifo: synchronous FIFO, FIFO_DEPTH × command width, with full/empty flags and async active-low reset.
- FSM and field-increment logic live in array_cmd_sequencer.

## Test plan
- Reset/idle: hold rst_n=0, then release.
  - op_code=11, addr=0, data_bank=0, data_in=0, busy=0, cmd_ready=1.
  - Assert rst_n=0 mid-sweep: outputs return to these values immediately.
- Single write: op=01, addr=9'b0000_00_000, data_bank=16'h00FF, count=0.
  - One cycle later: op_code=01, addr=000, data_bank=00FF, cmd_done=1 for 1 cycle, then op_code=11.
- Row sweep read: op=00, addr=9'b0110_10_101, count=3, sweep=1.
  - Rows 2,3,0,1 on consecutive cycles; bank=0110 and col=101 constant.
  - cmd_done only on the row-1 cycle.
- Column sweep search: op=10, addr=9'b0000_00_110, data_bank=16'h000F, count=2, sweep=1.
  - col 110, 111, 000; row and bank unchanged.
- Back-to-back and full: push 4 commands while the sequencer is stalled in a count=15 NOP.
  - cmd_ready=0 on the 5th; a push attempt is ignored.
  - Queued commands issue contiguously with no op_code=11 gap.
  - cmd_done count equals 5.
- NOP gap: write(count 0), NOP(count 2), read(count 0).
  - op_code sequence 01, 11, 11, 11, 00.
